// File: rtl/coin_pkg.sv
// Shared definitions for the coin acceptor: FSM state encoding, default
// parameter values and counter-width helpers.
package coin_pkg;

    // Acceptor FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUALIFY = 3'd1,
        HELD    = 3'd2,
        RELEASE = 3'd3,
        JAM     = 3'd4
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int JAM_CYCLES_DEF      = 64;

    // Bits needed to hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W_DEF  = cnt_width(DEBOUNCE_CYCLES_DEF);
    localparam int HCNT_W_DEF = cnt_width(JAM_CYCLES_DEF);

    // Saturation value of the optional coin total.
    localparam logic [15:0] TOTAL_MAX = 16'hFFFF;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs; async active-high reset to 0.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the raw sensor, emits one
// single-cycle coin pulse per physical coin and flags a stuck-high slot as a
// sticky jam until cleared.
// Optional macro COIN_ACCEPTOR_COUNT_EN adds a saturating 16-bit coin_total
// counter with a synchronous total_clear input.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int JAM_CYCLES      = JAM_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sensor_in,
    input  logic        enable,
    input  logic        jam_clear,
    output logic        coin,
    output logic        jam
`ifdef COIN_ACCEPTOR_COUNT_EN
    ,
    input  logic        total_clear,
    output logic [15:0] coin_total
`endif
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(JAM_CYCLES);

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0] HCNT_ONE  = HW'(1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(JAM_CYCLES - 1);

    logic          s_s;
    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [HW-1:0] hcnt_r, hcnt_s;
    logic          coin_r, coin_s;
    logic          jam_r, jam_s;

    sync2 #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sensor_in),
        .q     (s_s)
    );

    // Next-state, counter and output decode for the acceptor FSM.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        hcnt_s  = hcnt_r;
        coin_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (s_s && enable) begin
                    state_s = QUALIFY;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            QUALIFY: begin
                // enable falling on the acceptance edge still rejects the coin
                if (!s_s || !enable) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = HELD;
                    cnt_s   = CNT_ZERO;
                    hcnt_s  = HCNT_ZERO;
                    coin_s  = 1'b1;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            HELD: begin
                if (!s_s) begin
                    state_s = RELEASE;
                    cnt_s   = CNT_ONE;
                end else if (hcnt_r == HCNT_LAST) begin
                    state_s = JAM;
                end else begin
                    hcnt_s  = hcnt_r + HCNT_ONE;
                end
            end
            RELEASE: begin
                // a return high here is release bounce of the same coin
                if (s_s) begin
                    state_s = HELD;
                    hcnt_s  = HCNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            JAM: begin
                if (jam_clear && !s_s) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                    hcnt_s  = HCNT_ZERO;
                end else begin
                    state_s = JAM;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
                hcnt_s  = HCNT_ZERO;
            end
        endcase
        jam_s = (state_s == JAM);
    end

    // State, counter and registered-output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            hcnt_r  <= HCNT_ZERO;
            coin_r  <= 1'b0;
            jam_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            hcnt_r  <= hcnt_s;
            coin_r  <= coin_s;
            jam_r   <= jam_s;
        end
    end

    assign coin = coin_r;
    assign jam  = jam_r;

`ifdef COIN_ACCEPTOR_COUNT_EN
    logic [15:0] total_r;

    // Saturating coin total; a clear coinciding with a pulse leaves 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_r <= 16'd0;
        end else if (total_clear) begin
            total_r <= coin_r ? 16'd1 : 16'd0;
        end else if (coin_r && (total_r != TOTAL_MAX)) begin
            total_r <= total_r + 16'd1;
        end else begin
            total_r <= total_r;
        end
    end

    assign coin_total = total_r;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor (DEBOUNCE_CYCLES=4, JAM_CYCLES=16).
// Reference model tracks run lengths of the synchronised sensor per phase.
module tb_coin_acceptor;
    import coin_pkg::*;

    localparam int D = 4;
    localparam int J = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sensor_in = 1'b0;
    logic enable = 1'b0;
    logic jam_clear = 1'b0;
    logic coin;
    logic jam;
`ifdef COIN_ACCEPTOR_COUNT_EN
    logic        total_clear = 1'b0;
    logic [15:0] coin_total;
`endif

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(D), .JAM_CYCLES(J)) dut (
        .clk       (clk),
        .reset     (reset),
        .sensor_in (sensor_in),
        .enable    (enable),
        .jam_clear (jam_clear),
        .coin      (coin),
        .jam       (jam)
`ifdef COIN_ACCEPTOR_COUNT_EN
        ,
        .total_clear (total_clear),
        .coin_total  (coin_total)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: phase 0 = waiting for coin, 1 = coin in slot, 2 = jammed.
    int   m_phase;
    int   m_run;        // consecutive enabled-high samples while waiting
    int   m_hold;       // consecutive high samples while coin in slot
    int   m_low;        // consecutive low samples while coin in slot
    logic m_s1, m_s;    // two-sample delay of sensor_in
    logic m_coin, m_jam;
    int   m_total;
    int   pulses;
    logic prev_coin;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_run = 0; m_hold = 0; m_low = 0;
        m_s1 = 1'b0; m_s = 1'b0; m_coin = 1'b0; m_jam = 1'b0;
        m_total = 0; prev_coin = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic jc, input logic tc);
        logic accept;
        accept = 1'b0;
        case (m_phase)
            0: begin
                if (m_s && en) begin
                    m_run++;
                    if (m_run == D) begin
                        accept = 1'b1; m_phase = 1; m_hold = 0; m_low = 0; m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            1: begin
                if (!m_s) begin
                    m_low++;
                    if (m_low == D) begin m_phase = 0; m_run = 0; end
                end else if (m_low > 0) begin
                    m_low = 0; m_hold = 0;
                end else begin
                    m_hold++;
                    if (m_hold == J) m_phase = 2;
                end
            end
            default: begin
                if (jc && !m_s) begin m_phase = 0; m_run = 0; end
            end
        endcase
        if (tc) m_total = m_coin ? 1 : 0;
        else if (m_coin && m_total < 65535) m_total++;
        m_coin = accept;
        m_jam  = (m_phase == 2);
        m_s = m_s1;
        m_s1 = sensor_in;
    endtask

    task automatic check_outputs();
        chk("coin", {31'd0, coin}, {31'd0, m_coin});
        chk("jam", {31'd0, jam}, {31'd0, m_jam});
`ifdef COIN_ACCEPTOR_COUNT_EN
        chk("coin_total", {16'd0, coin_total}, m_total);
`endif
        if (coin === 1'b1) begin
            pulses++;
            chk("coin_back_to_back", {31'd0, prev_coin}, 32'd0);
        end
        prev_coin = coin;
    endtask

    // Called at a falling edge: apply inputs, clock once, check.
    task automatic tick(input logic si, input logic en, input logic jc, input logic tc);
        sensor_in = si; enable = en; jam_clear = jc;
`ifdef COIN_ACCEPTOR_COUNT_EN
        total_clear = tc;
`endif
        @(posedge clk);
        model_step(en, jc, tc);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input logic si, input logic en, input int len);
        for (int i = 0; i < len; i++) tick(si, en, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sensor_in = 1'b0; enable = 1'b1; jam_clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
    endtask

    typedef struct {
        logic si;
        logic en;
        logic jc;
        int   len;
        int   exp_pulses;
        logic exp_jam;
    } seg_t;

    seg_t tbl[16];
    int   p0;

    initial begin
        pulses = 0;
        model_reset();
        do_reset();
        chk("reset_coin", {31'd0, coin}, 32'd0);
        chk("reset_jam", {31'd0, jam}, 32'd0);
        chk("reset_state", {29'd0, dut.state_r}, {29'd0, IDLE});

        // Directed segments: clean coin, glitch, release bounce, jam, gating.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 10, 1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 10, 1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0,  3, 1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 10, 1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 10, 2, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0,  2, 2, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0,  2, 2, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 10, 2, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 30, 3, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1,  4, 3, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b1,  4, 3, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0,  4, 3, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 10, 4, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 10, 4, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 10, 4, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 10, 4, 1'b0};
        p0 = pulses;
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < tbl[i].len; c++) tick(tbl[i].si, tbl[i].en, tbl[i].jc, 1'b0);
            chk($sformatf("seg%0d_pulses", i), pulses - p0, tbl[i].exp_pulses);
            chk($sformatf("seg%0d_jam", i), {31'd0, jam}, {31'd0, tbl[i].exp_jam});
        end
        chk("idle_after_table", {29'd0, dut.state_r}, {29'd0, IDLE});

        // Latency: sensor first sampled high at edge 0, pulse only after edge 5.
        for (int n = 0; n < 10; n++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("latency_n%0d", n), {31'd0, coin}, (n == 5) ? 32'd1 : 32'd0);
        end
        run(1'b0, 1'b1, 10);

        // enable falls on the acceptance edge: no pulse.
        p0 = pulses;
        for (int n = 0; n < 10; n++) tick(1'b1, (n < 5) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        run(1'b0, 1'b1, 10);
        chk("enable_fall_at_accept", pulses - p0, 0);

        // Reset mid-QUALIFY (cnt=2 after edge 3).
        for (int n = 0; n < 4; n++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_reset_cnt", {30'd0, dut.cnt_r}, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("midq_reset_coin", {31'd0, coin}, 32'd0);
        chk("midq_reset_jam", {31'd0, jam}, 32'd0);
        chk("midq_reset_state", {29'd0, dut.state_r}, {29'd0, IDLE});
        sensor_in = 1'b0;
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        p0 = pulses;
        run(1'b0, 1'b1, 10);
        chk("no_pulse_after_reset", pulses - p0, 0);

        // Reset while jammed drops jam without a clock edge.
        run(1'b1, 1'b1, 30);
        chk("jam_before_reset", {31'd0, jam}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("jam_async_reset", {31'd0, jam}, 32'd0);
        sensor_in = 1'b0;
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        run(1'b0, 1'b1, 6);

`ifdef COIN_ACCEPTOR_COUNT_EN
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            run(1'b1, 1'b1, 10);
            run(1'b0, 1'b1, 10);
        end
        chk("total_three", {16'd0, coin_total}, 32'd3);
        for (int n = 0; n < 10; n++) tick(1'b1, 1'b1, 1'b0, (n == 6) ? 1'b1 : 1'b0);
        chk("total_clear_with_pulse", {16'd0, coin_total}, 32'd1);
        run(1'b0, 1'b1, 10);
`endif

        // Randomised bursts against the model.
        for (int b = 0; b < 300; b++) begin
            logic si, en;
            int len;
            si  = $urandom_range(1, 0) == 1;
            en  = $urandom_range(7, 0) != 0;
            len = (si && $urandom_range(9, 0) == 0) ? 25 : $urandom_range(8, 1);
            for (int c = 0; c < len; c++)
                tick(si, en, $urandom_range(5, 0) == 0, $urandom_range(15, 0) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
